// File: rtl/exu_mem_bus_master.sv
// Data-side bus master: registers one core load/store and runs it over a req/gnt/rvalid bus.
// Optional bus timeout abort is compiled in with `define LSU_BUS_TIMEOUT_EN.
module exu_mem_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_be_i,
    input  logic        core_we_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    output logic        bus_we_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_REQ  = 4'b0010;
    localparam logic [3:0] S_WAIT = 4'b0100;
    localparam logic [3:0] S_RESP = 4'b1000;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("exu_mem_bus_master: TIMEOUT_CYCLES out of range 2..65535");
    end

    logic [3:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_hit;

`ifdef LSU_BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counter is held at zero while idle, so it starts from zero on entering REQ
    // and keeps counting across REQ -> WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // >= rather than == so a grant landing on the limit cycle still aborts in WAIT.
    assign tmo_hit = (tmo_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    be_d    = core_be_i;
                    we_d    = core_we_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    err_d = bus_err_i;
                    if (!we_q) rdata_d = bus_rdata_i;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops them asynchronously.
    assign core_gnt_o    = (state_q == S_IDLE) && core_req_i;
    assign core_rvalid_o = (state_q == S_RESP);
    assign core_rdata_o  = rdata_q;
    assign core_err_o    = err_q;
    assign bus_req_o     = (state_q == S_REQ);
    assign bus_addr_o    = addr_q;
    assign bus_wdata_o   = wdata_q;
    assign bus_be_o      = be_q;
    assign bus_we_o      = we_q;

endmodule

// File: tb/tb_exu_mem_bus_master.sv
// Bench for exu_mem_bus_master: directed scenarios plus random transactions against a
// transaction-level model. Timeout scenario follows whether LSU_BUS_TIMEOUT_EN is defined.
module tb_exu_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i, core_we_i, core_gnt_o, core_rvalid_o, core_err_o;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic [3:0]  core_be_i, bus_be_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    exu_mem_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_be_i(core_be_i), .core_we_i(core_we_i), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_be_o(bus_be_o), .bus_we_o(bus_we_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic we);
        chk("bus_req_hi", 32'(bus_req_o), 32'd1);
        chk("bus_addr",   bus_addr_o, a);
        chk("bus_wdata",  bus_wdata_o, wd);
        chk("bus_be",     32'(bus_be_o), 32'(be));
        chk("bus_we",     32'(bus_we_o), 32'(we));
    endtask

    // One full transaction: gd cycles without grant, rd cycles in WAIT before rvalid.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic we, input int gd, input int rd, input logic [31:0] rdat,
                          input logic err, input logic hold_req, input logic spur);
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = a; core_wdata_i = wd; core_be_i = be; core_we_i = we;
        #1 chk("gnt_idle", 32'(core_gnt_o), 32'd1);
        chk("bus_req_idle", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        core_req_i = hold_req;
        core_addr_i = $urandom; core_wdata_i = $urandom; core_be_i = 4'($urandom);
        core_we_i = ~we;
        #1 chk("gnt_busy", 32'(core_gnt_o), 32'd0);
        for (int i = 0; i <= gd; i++) begin
            chk_bus(a, wd, be, we);
            chk("rvalid_req", 32'(core_rvalid_o), 32'd0);
            bus_rvalid_i = spur;
            bus_gnt_i = (i == gd);
            @(negedge clk);
        end
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        chk("bus_req_drop", 32'(bus_req_o), 32'd0);
        for (int i = 0; i <= rd; i++) begin
            chk("rvalid_wait", 32'(core_rvalid_o), 32'd0);
            bus_gnt_i = spur && (i != rd);
            bus_rvalid_i = (i == rd);
            bus_rdata_i = (i == rd) ? rdat : $urandom;
            bus_err_i = (i == rd) ? err : 1'($urandom);
            @(negedge clk);
        end
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
        if (!we) exp_rdata = rdat;
        #1;
        chk("rvalid_resp", 32'(core_rvalid_o), 32'd1);
        chk("rdata_resp", core_rdata_o, exp_rdata);
        chk("err_resp", 32'(core_err_o), 32'(err));
        chk("gnt_resp", 32'(core_gnt_o), 32'd0);
        core_req_i = 1'b0;
        @(negedge clk);
        chk("rvalid_pulse", 32'(core_rvalid_o), 32'd0);
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0;
        core_req_i = 0; core_addr_i = 0; core_wdata_i = 0; core_be_i = 0; core_we_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
        exp_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("rst_rdata", core_rdata_o, 32'd0);
        chk("rst_err", 32'(core_err_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        rst_n = 1'b1;

        // Zero-wait load, then delayed-grant store that must not touch read data.
        do_txn(32'h100, 32'h0, 4'hF, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        do_txn(32'h204, 32'hAB000000, 4'b1100, 1'b1, 5, 0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        // Error load followed by a clean load.
        do_txn(32'h300, 32'h0, 4'hF, 1'b0, 1, 1, 32'hCAFE0001, 1'b1, 1'b0, 1'b0);
        do_txn(32'h304, 32'h0, 4'hF, 1'b0, 0, 2, 32'hCAFE0002, 1'b0, 1'b1, 1'b1);

        // Spurious bus handshakes while idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid_i = 1'b1; bus_gnt_i = 1'b1; bus_rdata_i = $urandom;
            #1 chk("spur_rvalid", 32'(core_rvalid_o), 32'd0);
            chk("spur_bus_req", 32'(bus_req_o), 32'd0);
            chk("spur_rdata", core_rdata_o, exp_rdata);
        end
        @(negedge clk); bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        do_txn(32'h400, 32'h0, 4'h3, 1'b0, 0, 0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);

        // Reset while in REQ: bus_req_o must drop without waiting for a clock.
        @(negedge clk); core_req_i = 1'b1; core_we_i = 1'b0;
        @(negedge clk); core_req_i = 1'b0;
        #1 chk("req_before_rst", 32'(bus_req_o), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_req_drop", 32'(bus_req_o), 32'd0);
        exp_rdata = 32'h0;
        @(negedge clk); rst_n = 1'b1;

        // Reset while in WAIT, then a late rvalid that must be ignored.
        @(negedge clk); core_req_i = 1'b1;
        @(negedge clk); core_req_i = 1'b0; bus_gnt_i = 1'b1;
        @(negedge clk); bus_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_wait_req", 32'(bus_req_o), 32'd0);
        chk("rst_wait_rvalid", 32'(core_rvalid_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55AA55AA;
        @(negedge clk); bus_rvalid_i = 1'b0;
        chk("late_rvalid_0", 32'(core_rvalid_o), 32'd0);
        @(negedge clk);
        chk("late_rvalid_1", 32'(core_rvalid_o), 32'd0);
        chk("late_rdata", core_rdata_o, exp_rdata);

        // Random transactions; total REQ+WAIT time stays below the timeout.
        for (int n = 0; n < 20; n++) begin
            do_txn($urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), $urandom, 1'($urandom), 1'($urandom),
                   1'($urandom));
        end

        // Unanswered request.
        @(negedge clk); core_req_i = 1'b1; core_we_i = 1'b0;
        @(negedge clk); core_req_i = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_req_o !== 1'b1 || core_rvalid_o !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("tmo_waiting", 32'(bad), 32'd0);
        chk("tmo_rvalid", 32'(core_rvalid_o), 32'd1);
        chk("tmo_err", 32'(core_err_o), 32'd1);
        chk("tmo_rdata", core_rdata_o, exp_rdata);
        chk("tmo_bus_req", 32'(bus_req_o), 32'd0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77777777;
        @(negedge clk); bus_rvalid_i = 1'b0;
        chk("tmo_late_0", 32'(core_rvalid_o), 32'd0);
        @(negedge clk);
        chk("tmo_late_1", 32'(core_rvalid_o), 32'd0);
        chk("tmo_late_rdata", core_rdata_o, exp_rdata);
`else
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus_req_o !== 1'b1 || core_rvalid_o !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("no_tmo_waiting", 32'(bad), 32'd0);
        bus_gnt_i = 1'b1;
        @(negedge clk); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h13579BDF;
        @(negedge clk); bus_rvalid_i = 1'b0;
        chk("no_tmo_rvalid", 32'(core_rvalid_o), 32'd1);
        chk("no_tmo_rdata", core_rdata_o, 32'h13579BDF);
        chk("no_tmo_err", 32'(core_err_o), 32'd0);
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
